// File: rtl/mon_chain_pkg.sv
// Shared definitions for the monitor-chain reader.
//   RWI   : default stream word width
//   NCH   : default number of channel words per frame
//   state_t : reader FSM states
//   ch_w()  : width of a channel index (at least 1 bit)
package mon_chain_pkg;

    localparam int RWI = 28;
    localparam int NCH = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/double_diff_mux.sv
// Time-multiplexed per-channel double differentiator (CIC comb section).
// Holds the previous word xp[ch] and previous first difference dp[ch] for every
// channel and produces y = (x - xp) - dp two register stages after i_vld.
// Optional output rounding is enabled by macro MON_CHAIN_READER_ROUND_EN.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_vld      : accepted word strobe
//   i_ch       : channel of the accepted word
//   i_x        : accepted word
//   i_en       : result enable (warm-up complete) carried with the word
//   i_last     : word is the last channel of its frame
//   o_y/o_ch   : comb output and its channel
//   o_vld      : result strobe (i_vld & i_en delayed)
//   o_last     : frame-end strobe (i_vld & i_last delayed)
module double_diff_mux
    import mon_chain_pkg::*;
#(
    parameter int rwi    = RWI,
    parameter int nch    = NCH,
    parameter int oshift = 0,
    parameter int chw    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_vld,
    input  logic [chw-1:0]        i_ch,
    input  logic signed [rwi-1:0] i_x,
    input  logic                  i_en,
    input  logic                  i_last,
    output logic signed [rwi-1:0] o_y,
    output logic [chw-1:0]        o_ch,
    output logic                  o_vld,
    output logic                  o_last
);

`ifdef MON_CHAIN_READER_ROUND_EN
    localparam int SH = oshift;
`else
    localparam int SH = 0 * oshift;
`endif
    // Half-LSB of the shifted output; zero when no shift is applied.
    localparam logic [rwi:0]          ONE_W = {{rwi{1'b0}}, 1'b1};
    localparam logic [rwi:0]          RND_W = (ONE_W << SH) >> 1;
    localparam logic signed [rwi-1:0] RND   = $signed(RND_W[rwi-1:0]);

    logic signed [rwi-1:0] r_xp [nch];
    logic signed [rwi-1:0] r_dp [nch];

    logic                  r_s1_vld;
    logic [chw-1:0]        r_s1_ch;
    logic signed [rwi-1:0] r_s1_x;
    logic                  r_s1_en;
    logic                  r_s1_last;

    logic signed [rwi-1:0] w_xp;
    logic signed [rwi-1:0] w_dp;
    logic signed [rwi-1:0] w_d1;
    logic signed [rwi-1:0] w_y;
    logic signed [rwi-1:0] w_rnd;
    logic signed [rwi-1:0] w_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_ch   <= '0;
            r_s1_x    <= '0;
            r_s1_en   <= 1'b0;
            r_s1_last <= 1'b0;
        end else begin
            r_s1_vld  <= i_vld;
            r_s1_ch   <= i_ch;
            r_s1_x    <= i_x;
            r_s1_en   <= i_vld & i_en;
            r_s1_last <= i_vld & i_last;
        end
    end

    // Wrapping two's-complement arithmetic: integrator overflow upstream cancels here.
    always_comb begin
        w_xp  = r_xp[r_s1_ch];
        w_dp  = r_dp[r_s1_ch];
        w_d1  = r_s1_x - w_xp;
        w_y   = w_d1 - w_dp;
        w_rnd = w_y + RND;
        w_out = w_rnd >>> SH;
    end

    // State is updated even during warm-up so the comb history is primed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < nch; i++) begin
                r_xp[i] <= '0;
                r_dp[i] <= '0;
            end
            o_y    <= '0;
            o_ch   <= '0;
            o_vld  <= 1'b0;
            o_last <= 1'b0;
        end else begin
            o_vld  <= 1'b0;
            o_last <= 1'b0;
            if (r_s1_vld) begin
                r_xp[r_s1_ch] <= r_s1_x;
                r_dp[r_s1_ch] <= w_d1;
                o_y           <= w_out;
                o_ch          <= r_s1_ch;
                o_vld         <= r_s1_en;
                o_last        <= r_s1_last;
            end
        end
    end

endmodule

// File: rtl/mon_chain_reader.sv
// Reads frames of nch channel words from a serializer chain and passes them
// through a per-channel double differentiator. Tracks warm-up, overrun and
// short-frame conditions. Optional output rounding: MON_CHAIN_READER_ROUND_EN.
//   clk, rst_n           : clock, asynchronous active-low reset
//   samp                 : frame strobe
//   s_in, g_in           : stream word and its gate
//   err_clr              : clears sticky error flags
//   result, result_ch    : comb output and channel
//   result_valid         : result strobe (suppressed during warm-up)
//   frame_done           : strobe with the last channel's result slot
//   overrun, short_frame : sticky error flags
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | no frame open; gated words discarded
// ST_COLLECT | accepting words for channel idx
// ST_DONE    | frame complete; extra gated words flag overrun
module mon_chain_reader
    import mon_chain_pkg::*;
#(
    parameter int rwi    = RWI,
    parameter int nch    = NCH,
    parameter int oshift = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      samp,
    input  logic signed [rwi-1:0]     s_in,
    input  logic                      g_in,
    input  logic                      err_clr,
    output logic signed [rwi-1:0]     result,
    output logic [ch_w(nch)-1:0]      result_ch,
    output logic                      result_valid,
    output logic                      frame_done,
    output logic                      overrun,
    output logic                      short_frame
);

    localparam int             CHW      = ch_w(nch);
    localparam logic [CHW-1:0] LAST_IDX = CHW'(nch - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CHW-1:0] r_idx;
    logic [CHW-1:0] w_idx_nxt;
    logic [CHW-1:0] w_ch;
    logic           w_accept;
    logic           w_last;
    logic           w_ovr_evt;
    logic           w_short_evt;
    logic [1:0]     r_frm;
    logic           w_warm;

    // samp is resolved before g_in so a coincident word lands as channel 0.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ch        = r_idx;
        w_accept    = 1'b0;
        w_ovr_evt   = 1'b0;
        w_short_evt = 1'b0;
        if (samp) begin
            w_short_evt = (r_state == ST_COLLECT);
            w_ch        = '0;
            w_state_nxt = ST_COLLECT;
            w_idx_nxt   = '0;
            if (g_in) begin
                w_accept = 1'b1;
                if (LAST_IDX == '0)
                    w_state_nxt = ST_DONE;
                else
                    w_idx_nxt = CHW'(1);
            end
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (g_in) begin
                        w_accept = 1'b1;
                        if (r_idx == LAST_IDX) begin
                            w_state_nxt = ST_DONE;
                            w_idx_nxt   = '0;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end
                end
                ST_DONE:  w_ovr_evt = g_in;
                default:  ;
            endcase
        end
    end

    assign w_last = w_accept && (w_ch == LAST_IDX);
    // Warm-up status is captured with each word so the flag travels with it.
    assign w_warm = (r_frm == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_frm   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_last && (r_frm != 2'd2))
                r_frm <= r_frm + 2'd1;
        end
    end

    // A same-cycle error event takes priority over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            if (w_ovr_evt)
                overrun <= 1'b1;
            else if (err_clr)
                overrun <= 1'b0;
            if (w_short_evt)
                short_frame <= 1'b1;
            else if (err_clr)
                short_frame <= 1'b0;
        end
    end

    double_diff_mux #(
        .rwi    (rwi),
        .nch    (nch),
        .oshift (oshift),
        .chw    (CHW)
    ) u_comb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_vld  (w_accept),
        .i_ch   (w_ch),
        .i_x    (s_in),
        .i_en   (w_warm),
        .i_last (w_last),
        .o_y    (result),
        .o_ch   (result_ch),
        .o_vld  (result_valid),
        .o_last (frame_done)
    );

endmodule
